luma_stream: RTL and testbench

LUMA_STREAM -- requirements
Module: luma_stream

---
 rtl/luma_pkg.sv | 32 +++
 rtl/luma_weighted_sum.sv | 32 +++
 rtl/luma_stream.sv | 120 ++++++++++++
 tb/tb_luma_stream.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/luma_pkg.sv
// Shared constants and types for the luma_stream RGB-to-grayscale pipeline.
// Holds the 8-fractional-bit luma coefficients, the rounding constant and the
// frame-tracking FSM encoding. Rec.709 constants exist only when the optional
// LUMA_STREAM_709_EN macro is defined.
package luma_pkg;

  localparam int unsigned COEF_FRAC_W = 8;
  localparam int unsigned ROUND_C     = 128;

  typedef enum logic {
    FRAME_START = 1'b0,
    IN_FRAME    = 1'b1
  } frame_state_e;

  typedef struct packed {
    logic [COEF_FRAC_W-1:0] r;
    logic [COEF_FRAC_W-1:0] g;
    logic [COEF_FRAC_W-1:0] b;
  } coef_t;

  localparam coef_t COEF_601 = '{r: 8'd77, g: 8'd150, b: 8'd29};

`ifdef LUMA_STREAM_709_EN
  localparam coef_t COEF_709 = '{r: 8'd54, g: 8'd183, b: 8'd19};

  // Mode 0 selects Rec.601, mode 1 selects Rec.709.
  function automatic coef_t coef_for_mode(input logic mode);
    return mode ? COEF_709 : COEF_601;
  endfunction
`endif

endpackage

// File: rtl/luma_weighted_sum.sv
// Combinational sum of the three weighted subpixels, rounded and saturated.
// Ports:
//   prod_r_i/prod_g_i/prod_b_i : subpixel x coefficient products (P_SUB_W+8 bits)
//   luma_o                     : rounded, saturated luma (P_SUB_W bits)
module luma_weighted_sum
  import luma_pkg::*;
#(
  parameter int unsigned P_SUB_W = 8
) (
  input  logic [P_SUB_W+COEF_FRAC_W-1:0] prod_r_i,
  input  logic [P_SUB_W+COEF_FRAC_W-1:0] prod_g_i,
  input  logic [P_SUB_W+COEF_FRAC_W-1:0] prod_b_i,
  output logic [P_SUB_W-1:0]             luma_o
);

  localparam int unsigned ACC_W = P_SUB_W + 10;

  logic [ACC_W-1:0] acc_c;
  logic [ACC_W-1:0] scaled_c;

  // Round to nearest, drop the fraction, clamp to the subpixel range.
  always_comb begin
    acc_c    = ACC_W'(prod_r_i) + ACC_W'(prod_g_i) + ACC_W'(prod_b_i) + ACC_W'(ROUND_C);
    scaled_c = acc_c >> COEF_FRAC_W;
    if (scaled_c > ACC_W'({P_SUB_W{1'b1}})) begin
      luma_o = '1;
    end else begin
      luma_o = scaled_c[P_SUB_W-1:0];
    end
  end

endmodule

// File: rtl/luma_stream.sv
// Two-stage streaming RGB-to-luma converter with valid/ready handshakes.
// Stage 1 registers the three weighted products, stage 2 the rounded luma.
// A two-state FSM tracks frame boundaries; with LUMA_STREAM_709_EN defined it
// also latches I_MODE at the first beat of each frame to pick Rec.601/709.
// Ports:
//   I_CLK, I_RESET          : clock, synchronous active-high reset
//   I_PIXEL/I_VALID/I_LAST  : input beat (R high, G middle, B low subpixel)
//   I_MODE                  : coefficient set for a new frame (0=601, 1=709)
//   O_READY                 : input beat accepted this cycle (combinational)
//   O_PIXEL/O_VALID/O_LAST  : output beat
//   I_READY                 : downstream accepts an output beat
module luma_stream
  import luma_pkg::*;
#(
  parameter int unsigned P_PIXEL_DEPTH = 24
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET,
  input  logic [P_PIXEL_DEPTH-1:0]   I_PIXEL,
  input  logic                       I_VALID,
  input  logic                       I_LAST,
  input  logic                       I_MODE,
  output logic                       O_READY,
  output logic [P_PIXEL_DEPTH/3-1:0] O_PIXEL,
  output logic                       O_VALID,
  output logic                       O_LAST,
  input  logic                       I_READY
);

  localparam int unsigned S    = P_PIXEL_DEPTH / 3;
  localparam int unsigned SP_W = S + COEF_FRAC_W;

  frame_state_e     state_q;
  logic             s1_valid_q;
  logic             s1_last_q;
  logic [SP_W-1:0]  prod_r_q, prod_g_q, prod_b_q;
  logic [SP_W-1:0]  prod_r_d, prod_g_d, prod_b_d;
  logic             o_valid_q;
  logic             o_last_q;
  logic [S-1:0]     o_pixel_q;
  logic [S-1:0]     luma_c;
  logic             en_c;
  coef_t            coef_c;

`ifdef LUMA_STREAM_709_EN
  logic             mode_q;
`else
  logic             unused_mode;
  assign unused_mode = I_MODE;
`endif

  // Pipeline advances whenever the output register is empty or being drained.
  assign en_c    = !o_valid_q || I_READY;
  assign O_READY = en_c || I_RESET;
  assign O_PIXEL = o_pixel_q;
  assign O_VALID = o_valid_q;
  assign O_LAST  = o_last_q;

  // First beat of a frame uses I_MODE directly; later beats use the latched mode.
  always_comb begin
`ifdef LUMA_STREAM_709_EN
    coef_c = coef_for_mode((state_q == FRAME_START) ? I_MODE : mode_q);
`else
    coef_c = COEF_601;
`endif
    prod_r_d = SP_W'(I_PIXEL[3*S-1:2*S]) * SP_W'(coef_c.r);
    prod_g_d = SP_W'(I_PIXEL[2*S-1:S])   * SP_W'(coef_c.g);
    prod_b_d = SP_W'(I_PIXEL[S-1:0])     * SP_W'(coef_c.b);
  end

  luma_weighted_sum #(
    .P_SUB_W (S)
  ) u_weighted_sum (
    .prod_r_i (prod_r_q),
    .prod_g_i (prod_g_q),
    .prod_b_i (prod_b_q),
    .luma_o   (luma_c)
  );

  // Pipeline registers and frame FSM; everything holds while en_c is low.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q    <= FRAME_START;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      prod_r_q   <= '0;
      prod_g_q   <= '0;
      prod_b_q   <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_pixel_q  <= '0;
`ifdef LUMA_STREAM_709_EN
      mode_q     <= 1'b0;
`endif
    end else if (en_c) begin
      s1_valid_q <= I_VALID;
      s1_last_q  <= I_VALID && I_LAST;
      prod_r_q   <= prod_r_d;
      prod_g_q   <= prod_g_d;
      prod_b_q   <= prod_b_d;
      o_valid_q  <= s1_valid_q;
      o_last_q   <= s1_last_q;
      o_pixel_q  <= luma_c;
      if (I_VALID) begin
        case (state_q)
          FRAME_START: begin
`ifdef LUMA_STREAM_709_EN
            mode_q <= I_MODE;
`endif
            if (!I_LAST) state_q <= IN_FRAME;
          end
          IN_FRAME: begin
            if (I_LAST) state_q <= FRAME_START;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_luma_stream.sv
// Self-checking bench for luma_stream (P_PIXEL_DEPTH=24): directed cases plus
// randomized traffic against a frame-level reference model.
module tb_luma_stream;

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic [23:0] I_PIXEL;
  logic        I_VALID;
  logic        I_LAST;
  logic        I_MODE;
  logic        O_READY;
  logic [7:0]  O_PIXEL;
  logic        O_VALID;
  logic        O_LAST;
  logic        I_READY;

  luma_stream #(.P_PIXEL_DEPTH(24)) dut (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .I_PIXEL (I_PIXEL),
    .I_VALID (I_VALID),
    .I_LAST  (I_LAST),
    .I_MODE  (I_MODE),
    .O_READY (O_READY),
    .O_PIXEL (O_PIXEL),
    .O_VALID (O_VALID),
    .O_LAST  (O_LAST),
    .I_READY (I_READY)
  );

  always #5 I_CLK = ~I_CLK;

`ifdef LUMA_STREAM_709_EN
  localparam bit HAS709 = 1'b1;
`else
  localparam bit HAS709 = 1'b0;
`endif

  typedef struct {
    logic [7:0] pix;
    logic       last;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  bit         in_frame   = 1'b0;
  bit         frame_mode = 1'b0;
  bit         stall_chk  = 1'b0;
  logic [9:0] saved;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Luma from first principles: weighted average with 8-bit weights, rounded.
  function automatic logic [7:0] ref_luma(input logic [23:0] p, input bit m);
    int r, g, b, y;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    if (m) y = (r * 54 + g * 183 + b * 19 + 128) / 256;
    else   y = (r * 77 + g * 150 + b * 29 + 128) / 256;
    if (y > 255) y = 255;
    return 8'(y);
  endfunction

  // Observe one cycle at the falling edge, update the model, then advance.
  task automatic tick();
    exp_t e;
    @(negedge I_CLK);
    if (I_RESET) begin
      check(32'(O_READY), 32'd1, "ready_in_reset");
      q.delete();
      in_frame  = 1'b0;
      stall_chk = 1'b0;
    end else begin
      check(32'(O_READY), 32'(!O_VALID || I_READY), "ready_rule");
      if (stall_chk) check(32'({O_VALID, O_LAST, O_PIXEL}), 32'(saved), "stall_hold");
      if (O_VALID && I_READY) begin
        check(32'(q.size() > 0), 32'd1, "beat_expected");
        if (q.size() > 0) begin
          e = q.pop_front();
          check(32'(O_PIXEL), 32'(e.pix), "out_pixel");
          check(32'(O_LAST), 32'(e.last), "out_last");
        end
      end
      if (I_VALID && O_READY) begin
        if (!in_frame) frame_mode = HAS709 ? I_MODE : 1'b0;
        e.pix  = ref_luma(I_PIXEL, frame_mode);
        e.last = I_LAST;
        q.push_back(e);
        in_frame = !I_LAST;
      end
      stall_chk = O_VALID && !I_READY;
      saved     = {O_VALID, O_LAST, O_PIXEL};
    end
    @(posedge I_CLK);
    #1;
  endtask

  task automatic beat(input logic [23:0] p, input logic m, input logic l);
    I_PIXEL = p;
    I_MODE  = m;
    I_LAST  = l;
    I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
  endtask

  // Wait (bounded) for the next output beat, check it, then let it drain.
  task automatic expect_out(input logic [7:0] pix, input logic last, input string tag,
                            output int waited);
    waited = 0;
    while (!O_VALID && waited < 8) begin
      tick();
      waited++;
    end
    check(32'(O_VALID), 32'd1, {tag, "_valid"});
    check(32'(O_PIXEL), 32'(pix), {tag, "_pixel"});
    check(32'(O_LAST), 32'(last), {tag, "_last"});
    tick();
  endtask

  initial begin
    int         w;
    int         sent;
    logic [7:0] red_m1;

    red_m1  = HAS709 ? 8'd54 : 8'd77;
    I_RESET = 1'b1;
    I_PIXEL = '0;
    I_VALID = 1'b0;
    I_LAST  = 1'b0;
    I_MODE  = 1'b0;
    I_READY = 1'b0;
    tick();
    tick();
    I_RESET = 1'b0;
    #1;
    check(32'(O_VALID), 32'd0, "rst_valid");
    check(32'(O_LAST), 32'd0, "rst_last");
    check(32'(O_PIXEL), 32'd0, "rst_pixel");
    check(32'(O_READY), 32'd1, "rst_ready");
    I_READY = 1'b1;

    // White saturates to full scale with two-cycle latency.
    beat(24'hFFFFFF, 1'b0, 1'b1);
    expect_out(8'hFF, 1'b1, "white", w);
    check(32'(w), 32'd1, "white_latency");

    // Single-beat frames in each coefficient set.
    beat(24'hFF0000, 1'b0, 1'b1);
    expect_out(8'd77, 1'b1, "red_601", w);
    beat(24'hFF0000, 1'b1, 1'b1);
    expect_out(red_m1, 1'b1, "red_709", w);
    beat(24'h00FF00, 1'b0, 1'b1);
    expect_out(8'd149, 1'b1, "green_601", w);

    // Mode changes inside a frame are ignored until the next frame.
    beat(24'hFF0000, 1'b0, 1'b0);
    expect_out(8'd77, 1'b0, "frm_b1", w);
    beat(24'hFF0000, 1'b1, 1'b0);
    expect_out(8'd77, 1'b0, "frm_b2", w);
    beat(24'hFF0000, 1'b1, 1'b1);
    expect_out(8'd77, 1'b1, "frm_b3", w);
    beat(24'hFF0000, 1'b1, 1'b1);
    expect_out(red_m1, 1'b1, "frm_next", w);

    // Four-beat stream with a three-cycle downstream stall.
    sent = 0;
    for (int c = 0; c < 14; c++) begin
      I_READY = !(c >= 3 && c < 6);
      I_VALID = (sent < 4);
      I_PIXEL = 24'($urandom);
      I_LAST  = (sent == 3);
      I_MODE  = 1'($urandom);
      #1;
      if (c >= 3 && c < 6) check(32'(O_READY), 32'd0, "stall_ready_low");
      if (I_VALID && O_READY) sent++;
      tick();
    end
    I_VALID = 1'b0;
    check(32'(sent), 32'd4, "stall_sent");
    check(32'(q.size()), 32'd0, "stall_drained");

    // Reset with two beats in flight discards both and restarts the frame.
    I_READY = 1'b1;
    I_MODE  = 1'b0;
    I_LAST  = 1'b0;
    I_VALID = 1'b1;
    I_PIXEL = 24'h123456;
    tick();
    I_PIXEL = 24'h654321;
    tick();
    I_VALID = 1'b0;
    I_READY = 1'b0;
    I_RESET = 1'b1;
    tick();
    I_RESET = 1'b0;
    #1;
    check(32'(O_VALID), 32'd0, "rst_flush_valid");
    check(32'(O_READY), 32'd1, "rst_flush_ready");
    I_READY = 1'b1;
    repeat (3) tick();
    beat(24'hFF0000, 1'b1, 1'b1);
    expect_out(red_m1, 1'b1, "post_rst_frame", w);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 500; c++) begin
      I_RESET = ($urandom_range(0, 99) == 0);
      I_VALID = ($urandom_range(0, 3) != 0);
      I_READY = ($urandom_range(0, 3) != 0);
      I_PIXEL = 24'($urandom);
      I_LAST  = ($urandom_range(0, 3) == 0);
      I_MODE  = 1'($urandom);
      tick();
    end
    I_RESET = 1'b0;
    I_VALID = 1'b0;
    I_READY = 1'b1;
    repeat (4) tick();
    check(32'(q.size()), 32'd0, "rand_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
